fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program-counter/fetch stage for the 9-bit single-cycle core.
- Drives the address of the instruction ROM and consumes the control decoder's same-cycle outputs: Jump, BranchEn, TargSel and Ack, plus the ALU condition flag.
- Computes the next PC: sequential increment, absolute jump through a 4-entry target LUT, or relative branch through the same LUT.
- Owns the Start/Done program handshake with the testbench.

Parameters:
- PC_W, 10, program counter width in bits; the ROM depth is 2**PC_W.
- LUT0, 10'd0, entry 0: absolute jump target and signed branch offset.
- LUT1, 10'd0, entry 1, same use as LUT0.
- LUT2, 10'd0, entry 2, same use as LUT0.
- LUT3, 10'd0, entry 3, same use as LUT0.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  level request to (re)start the program.
- StartAddr  in  PC_W  PC loaded when a program starts.
- Jump  in  1  from decoder: absolute jump.
- BranchEn  in  1  from decoder: conditional relative branch.
- BranchTaken  in  1  ALU condition flag for the current instruction.
- TargSel  in  2  LUT index from the decoder.
- Ack  in  1  from decoder: current instruction is the halt instruction.
- ProgCtr  out  PC_W  instruction ROM address.
- Busy  out  1  high while in RUN.
- Done  out  1  high while in HALT.
- CycleCnt  out  16  only present when FETCH_CYCLE_CNT_EN is defined.

Behaviour:
- Reset is asynchronous. On Reset: state=IDLE, ProgCtr=0, Busy=0, Done=0.
- States:
  - IDLE: ProgCtr holds; Busy=0; Done=0.
  - RUN: ProgCtr advances every cycle; Busy=1.
  - HALT: ProgCtr frozen at the halt instruction's address; Done=1.
- Transitions:
  - IDLE and Start=1: next cycle ProgCtr=StartAddr, state=RUN.
  - RUN and Start=1: restart. ProgCtr=StartAddr, stay in RUN. Start has priority over every decoder input.
  - RUN and Ack=1 (Start=0): ProgCtr holds, state=HALT.
  - HALT and Start=1: ProgCtr=StartAddr, state=RUN. Done drops on that same edge.
  - HALT and Start=0: remain in HALT. Decoder inputs are ignored.
- Next-PC priority in RUN with Start=0 and Ack=0:
  1. Jump=1: ProgCtr=LUT[TargSel], absolute.
  2. Otherwise BranchEn=1 and BranchTaken=1: ProgCtr=ProgCtr+LUT[TargSel], modulo 2**PC_W. The LUT value acts as a two's-complement offset.
  3. Otherwise: ProgCtr=ProgCtr+1.
- Arithmetic: all additions are PC_W wide, with carry discarded. Increment from 2**PC_W-1 wraps to 0. Branch offset 10'h3FF means -1.
- Jump=1 together with BranchEn=1: the jump wins, and BranchTaken is ignored.
- Latency: the decoder and ALU observe the ROM output for the current ProgCtr combinationally. The redirect takes effect on the next rising edge, so there are no delay slots and no bubble.
- Reset asserted mid-RUN returns immediately to IDLE with ProgCtr=0. No Done pulse is produced.
- Start held high in RUN re-loads StartAddr every cycle. The bench must pulse Start for exactly one cycle.

Optional Feature:
- Macro: FETCH_CYCLE_CNT_EN.
- Defined: adds the 16-bit CycleCnt output.
  - Cleared to 0 by Reset and by every accepted Start.
  - Increments by 1 on each clock edge while in RUN.
  - Saturates at 16'hFFFF.
  - Holds its value in HALT and IDLE.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then a 1-cycle Start with StartAddr=5, then no control inputs for 3 cycles -> ProgCtr sequence 5,6,7,8; Busy=1; Done=0.
- In RUN at PC=20: Jump=1, TargSel=2, LUT2=100 -> next ProgCtr=100. Same test with BranchEn=1 also high -> still 100.
- At PC=50 with LUT1=10'h3FC (-4): BranchEn=1, TargSel=1, BranchTaken=1 -> 46. With BranchTaken=0 -> 51.
- At PC=10'h3FF with no control inputs -> ProgCtr=0.
- Ack=1 at PC=30 -> ProgCtr stays 30, Done=1, Busy=0 on the next cycle. Then Start with StartAddr=0 -> ProgCtr=0, Done=0, Busy=1.
- Reset asserted asynchronously mid-RUN at PC=12 -> outputs return to 0/IDLE immediately. With FETCH_CYCLE_CNT_EN: Start, then 7 RUN cycles, then Ack -> CycleCnt=7, held in HALT.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: program counter / fetch stage with Start/Done handshake and LUT-based jumps and branches.
// Define FETCH_CYCLE_CNT_EN to add the saturating 16-bit CycleCnt output.
module fetch_unit #(
    parameter int              PC_W = 10,
    parameter logic [PC_W-1:0] LUT0 = '0,
    parameter logic [PC_W-1:0] LUT1 = '0,
    parameter logic [PC_W-1:0] LUT2 = '0,
    parameter logic [PC_W-1:0] LUT3 = '0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [PC_W-1:0] StartAddr,
    input  logic            Jump,
    input  logic            BranchEn,
    input  logic            BranchTaken,
    input  logic [1:0]      TargSel,
    input  logic            Ack,
    output logic [PC_W-1:0] ProgCtr,
    output logic            Busy,
    output logic            Done
`ifdef FETCH_CYCLE_CNT_EN
    ,
    output logic [15:0]     CycleCnt
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t          state, state_next;
    logic [PC_W-1:0] pc_next, lut;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            ProgCtr <= '0;
        end else begin
            state   <= state_next;
            ProgCtr <= pc_next;
        end
    end

    // Start overrides everything; the LUT entry doubles as a two's-complement branch offset.
    always_comb begin
        lut        = TargSel == 2'd0 ? LUT0 : TargSel == 2'd1 ? LUT1 : TargSel == 2'd2 ? LUT2 : LUT3;
        state_next = state;
        pc_next    = ProgCtr;
        if (Start) begin
            state_next = RUN;
            pc_next    = StartAddr;
        end else if (state == RUN) begin
            if (Ack)
                state_next = HALT;
            else
                pc_next = Jump ? lut : (BranchEn && BranchTaken) ? ProgCtr + lut : ProgCtr + PC_W'(1);
        end
    end

    assign Busy = state == RUN;
    assign Done = state == HALT;

`ifdef FETCH_CYCLE_CNT_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            CycleCnt <= '0;
        else if (Start)
            CycleCnt <= '0;
        else if (state == RUN && CycleCnt != 16'hFFFF)
            CycleCnt <= CycleCnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a behavioural PC model.
module tb_fetch_unit;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [9:0] StartAddr = '0;
    logic       Jump = 1'b0;
    logic       BranchEn = 1'b0;
    logic       BranchTaken = 1'b0;
    logic [1:0] TargSel = '0;
    logic       Ack = 1'b0;
    logic [9:0] ProgCtr;
    logic       Busy;
    logic       Done;
`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] CycleCnt;
`endif

    int total = 0;
    int bad = 0;
    int lut[4] = '{300, 1020, 100, 7};
    int m_pc = 0;
    int m_st = 0;
    int m_cnt = 0;

    fetch_unit #(
        .PC_W(10),
        .LUT0(10'd300),
        .LUT1(10'h3FC),
        .LUT2(10'd100),
        .LUT3(10'd7)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .StartAddr(StartAddr),
        .Jump(Jump),
        .BranchEn(BranchEn),
        .BranchTaken(BranchTaken),
        .TargSel(TargSel),
        .Ack(Ack),
        .ProgCtr(ProgCtr),
        .Busy(Busy),
        .Done(Done)
`ifdef FETCH_CYCLE_CNT_EN
        ,
        .CycleCnt(CycleCnt)
`endif
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model state: 0 idle, 1 run, 2 halt; advanced from the inputs present before each edge.
    task automatic tick();
        if (Reset) begin
            m_pc = 0; m_st = 0; m_cnt = 0;
        end else if (Start) begin
            m_pc = int'(StartAddr); m_st = 1; m_cnt = 0;
        end else if (m_st == 1) begin
            m_cnt = m_cnt == 65535 ? m_cnt : m_cnt + 1;
            if (Ack) m_st = 2;
            else if (Jump) m_pc = lut[TargSel];
            else if (BranchEn && BranchTaken) m_pc = (m_pc + lut[TargSel]) % 1024;
            else m_pc = (m_pc + 1) % 1024;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_ctl();
        Start = 0; Jump = 0; BranchEn = 0; BranchTaken = 0; TargSel = 0; Ack = 0;
    endtask

    task automatic start_at(input logic [9:0] a);
        clear_ctl();
        Start = 1;
        StartAddr = a;
        tick();
        Start = 0;
    endtask

    task automatic test_reset();
        clear_ctl();
        Reset = 1;
        tick();
        tick();
        total++;
        if (ProgCtr !== 10'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
            bad++;
            $display("FAIL reset: pc=%0d busy=%b done=%b want 0/0/0", ProgCtr, Busy, Done);
        end
`ifdef FETCH_CYCLE_CNT_EN
        total++;
        if (CycleCnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_cnt: cnt=%0d want 0", CycleCnt);
        end
`endif
        Reset = 0;
        tick();
        total++;
        if (ProgCtr !== 10'd0 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: pc=%0d busy=%b want 0/0", ProgCtr, Busy);
        end
    endtask

    task automatic test_sequential();
        start_at(10'd5);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ProgCtr !== 10'(5 + i) || Busy !== 1'b1 || Done !== 1'b0) begin
                bad++;
                $display("FAIL seq[%0d]: pc=%0d busy=%b done=%b want %0d/1/0", i, ProgCtr, Busy, Done, 5 + i);
            end
            tick();
        end
    endtask

    task automatic test_jump();
        for (int b = 0; b < 2; b++) begin
            start_at(10'd20);
            total++;
            if (ProgCtr !== 10'd20) begin
                bad++;
                $display("FAIL jump_setup: pc=%0d want 20", ProgCtr);
            end
            Jump = 1; TargSel = 2; BranchEn = b[0]; BranchTaken = b[0];
            tick();
            clear_ctl();
            total++;
            if (ProgCtr !== 10'd100) begin
                bad++;
                $display("FAIL jump(branch=%0d): pc=%0d want 100", b, ProgCtr);
            end
        end
    endtask

    task automatic test_branch();
        for (int t = 1; t >= 0; t--) begin
            start_at(10'd50);
            BranchEn = 1; TargSel = 1; BranchTaken = t[0];
            tick();
            clear_ctl();
            total++;
            if (ProgCtr !== (t == 1 ? 10'd46 : 10'd51)) begin
                bad++;
                $display("FAIL branch(taken=%0d): pc=%0d want %0d", t, ProgCtr, t == 1 ? 46 : 51);
            end
        end
    endtask

    task automatic test_wrap();
        start_at(10'h3FF);
        tick();
        total++;
        if (ProgCtr !== 10'd0 || Busy !== 1'b1) begin
            bad++;
            $display("FAIL wrap: pc=%0d busy=%b want 0/1", ProgCtr, Busy);
        end
    endtask

    task automatic test_halt();
        start_at(10'd30);
        Ack = 1;
        tick();
        Ack = 0;
        total++;
        if (ProgCtr !== 10'd30 || Done !== 1'b1 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL halt: pc=%0d done=%b busy=%b want 30/1/0", ProgCtr, Done, Busy);
        end
        for (int i = 0; i < 3; i++) begin
            Jump = 1'($urandom); BranchEn = 1; BranchTaken = 1; TargSel = 2'($urandom); Ack = 1'($urandom);
            tick();
            total++;
            if (ProgCtr !== 10'd30 || Done !== 1'b1) begin
                bad++;
                $display("FAIL halt_hold[%0d]: pc=%0d done=%b want 30/1", i, ProgCtr, Done);
            end
        end
        start_at(10'd0);
        total++;
        if (ProgCtr !== 10'd0 || Done !== 1'b0 || Busy !== 1'b1) begin
            bad++;
            $display("FAIL halt_restart: pc=%0d done=%b busy=%b want 0/0/1", ProgCtr, Done, Busy);
        end
    endtask

    task automatic test_async_reset();
        start_at(10'd10);
        tick();
        tick();
        total++;
        if (ProgCtr !== 10'd12) begin
            bad++;
            $display("FAIL areset_setup: pc=%0d want 12", ProgCtr);
        end
        #2 Reset = 1;
        #1;
        total++;
        if (ProgCtr !== 10'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
            bad++;
            $display("FAIL areset: pc=%0d busy=%b done=%b want 0/0/0", ProgCtr, Busy, Done);
        end
        tick();
        Reset = 0;
        tick();
        total++;
        if (ProgCtr !== 10'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
            bad++;
            $display("FAIL areset_idle: pc=%0d busy=%b done=%b want 0/0/0", ProgCtr, Busy, Done);
        end
    endtask

    task automatic test_cycle_cnt();
`ifdef FETCH_CYCLE_CNT_EN
        start_at(10'd40);
        total++;
        if (CycleCnt !== 16'd0) begin
            bad++;
            $display("FAIL cnt_start: cnt=%0d want 0", CycleCnt);
        end
        repeat (6) tick();
        Ack = 1;
        tick();
        Ack = 0;
        total++;
        if (CycleCnt !== 16'd7 || Done !== 1'b1) begin
            bad++;
            $display("FAIL cnt_halt: cnt=%0d done=%b want 7/1", CycleCnt, Done);
        end
        repeat (3) tick();
        total++;
        if (CycleCnt !== 16'd7) begin
            bad++;
            $display("FAIL cnt_hold: cnt=%0d want 7", CycleCnt);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            Start = $urandom_range(0, 19) == 0;
            StartAddr = 10'($urandom);
            Ack = $urandom_range(0, 14) == 0;
            Jump = $urandom_range(0, 3) == 0;
            BranchEn = $urandom_range(0, 2) == 0;
            BranchTaken = 1'($urandom);
            TargSel = 2'($urandom);
            tick();
            total++;
            if (ProgCtr !== 10'(m_pc) || Busy !== (m_st == 1) || Done !== (m_st == 2)) begin
                bad++;
                $display("FAIL random[%0d]: pc=%0d busy=%b done=%b want %0d/%b/%b", i, ProgCtr, Busy, Done, m_pc, m_st == 1, m_st == 2);
            end
`ifdef FETCH_CYCLE_CNT_EN
            total++;
            if (CycleCnt !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL random_cnt[%0d]: cnt=%0d want %0d", i, CycleCnt, m_cnt);
            end
`endif
        end
        clear_ctl();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_branch();
        test_wrap();
        test_halt();
        test_async_reset();
        test_cycle_cnt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
